// File: rtl/prog_fetch_if.sv
// prog_fetch_if: bus between the instruction fetch unit, the program ROM
// and the execute stage.
//
// Parameters:
//   ADDR_W  - program address width
//   INSTR_W - instruction word width
//
// Signals:
//   rom_addr    - ROM address driven by fetch (combinational copy of pc)
//   rom_data    - ROM word at rom_addr, valid in the same cycle
//   instr       - registered instruction word
//   instr_valid - instr holds an instruction not yet accepted
//   instr_ready - execute accepts instr this cycle
//   jump_en     - redirect request, looked at only on accept
//   jump_addr   - redirect target
//   resume      - single-cycle pulse that leaves HALT
//   pc          - address of the current or next instruction
//   halted      - fetch unit is in HALT
//   state       - debug view of the fetch FSM (0 FETCH, 1 VALID, 2 HALT)
//
// Handshake: an instruction transfers on every rising edge where
// instr_valid && instr_ready are both 1. While instr_valid is 1 and
// instr_ready is 0, instr and pc hold. instr_valid never depends
// combinationally on instr_ready. jump_en/jump_addr take effect only on
// the transfer edge.
//
// Modports: master = fetch unit, slave = ROM + execute side.

interface prog_fetch_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 12
);
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_addr;
  logic               resume;
  logic [ADDR_W-1:0]  pc;
  logic               halted;
  logic [1:0]         state;

  modport master (
    output rom_addr,
    input  rom_data,
    output instr,
    output instr_valid,
    input  instr_ready,
    input  jump_en,
    input  jump_addr,
    input  resume,
    output pc,
    output halted,
    output state
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  instr,
    input  instr_valid,
    output instr_ready,
    output jump_en,
    output jump_addr,
    output resume,
    input  pc,
    input  halted,
    input  state
  );
endinterface

// File: rtl/prog_fetch.sv
// prog_fetch: instruction fetch unit for the 8-bit CPU.
//
// Owns the program counter, addresses the combinational program ROM,
// registers the fetched word and hands it to execute over a valid/ready
// handshake. Jump redirects are taken on accept; the HALT sentinel word
// parks the unit until a resume pulse.
//
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous, active-high reset
//   bus - prog_fetch_if.master (ROM address/data, instruction handshake,
//         jump redirect, resume, pc, halted, debug state)
//
// Configuration macro:
//   FETCH_HALT_DETECT_EN - when defined, fetching HALT_WORD enters HALT.
//                          When undefined, HALT is never entered, halted
//                          is 0, resume has no effect and HALT_WORD is
//                          delivered as an ordinary instruction.
//
// Throughput: one edge to fetch, one edge to accept, so at most one
// instruction every two cycles.

module prog_fetch #(
  parameter int                 ADDR_W    = 8,
  parameter int                 INSTR_W   = 12,
  parameter logic [ADDR_W-1:0]  RESET_PC  = 'd1,
  parameter logic [INSTR_W-1:0] HALT_WORD = 'h9FF
) (
  input logic          clk,
  input logic          rst,
  prog_fetch_if.master bus
);

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] PC_LAST = '1;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n;
  logic [INSTR_W-1:0] instr, instr_n;
  logic [ADDR_W-1:0]  next_pc;
  logic               is_halt_word;

  // Sequential wrap skips address 0; only an explicit jump can reach it.
  assign next_pc      = (pc == PC_LAST) ? RESET_PC : pc + 1'b1;
  assign is_halt_word = (bus.rom_data == HALT_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      instr <= instr_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr;
    case (state)
      FETCH: begin
        // The HALT word is latched too; pc stays on its address.
        instr_n = bus.rom_data;
        if (HALT_EN && is_halt_word) state_n = HALT;
        else                         state_n = VALID;
      end
      VALID: begin
        if (bus.instr_ready) begin
          pc_n    = bus.jump_en ? bus.jump_addr : next_pc;
          state_n = FETCH;
        end
      end
      HALT: begin
        // Only reachable with halt detection enabled.
        if (bus.resume) begin
          pc_n    = RESET_PC;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  assign bus.rom_addr    = pc;
  assign bus.pc          = pc;
  assign bus.instr       = instr;
  assign bus.instr_valid = (state == VALID);
  assign bus.state       = state;
`ifdef FETCH_HALT_DETECT_EN
  assign bus.halted      = (state == HALT);
`else
  assign bus.halted      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_fetch.sv
// tb_prog_fetch: directed self-checking bench for prog_fetch.
// A transaction-level model of the fetch unit runs beside the DUT and is
// compared on every falling edge; directed steps add literal checks.

module tb_prog_fetch;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit M_HALT_EN = 1'b1;
`else
  localparam bit M_HALT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  prog_fetch_if #(.ADDR_W(8), .INSTR_W(12)) bus ();

  prog_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [11:0] rom [0:255];
  assign bus.rom_data = rom[bus.rom_addr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // The model holds what execute should see: the address being worked
  // on, whether a word is waiting for it, and whether the unit is parked.
  // One edge fetches ROM[pc]; a transfer edge moves pc on.
  logic [7:0]  m_pc;
  logic [11:0] m_instr;
  bit          m_waiting;   // instruction presented, not yet taken
  bit          m_parked;    // sitting on a HALT word
  bit          m_enable_cmp = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 8'd1; m_instr = 12'h000; m_waiting = 0; m_parked = 0;
    end else if (m_parked) begin
      if (bus.resume) begin m_parked = 0; m_pc = 8'd1; end
    end else if (m_waiting) begin
      if (bus.instr_ready) begin
        m_waiting = 0;
        if (bus.jump_en)         m_pc = bus.jump_addr;
        else if (m_pc == 8'd255) m_pc = 8'd1;
        else                     m_pc = m_pc + 8'd1;
      end
    end else begin
      m_instr = rom[m_pc];
      if (M_HALT_EN && m_instr == 12'h9FF) m_parked = 1;
      else                                 m_waiting = 1;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (m_enable_cmp) begin
      check("cyc_pc", {24'd0, bus.pc}, {24'd0, m_pc});
      check("cyc_rom_addr", {24'd0, bus.rom_addr}, {24'd0, m_pc});
      check("cyc_valid", {31'd0, bus.instr_valid}, {31'd0, m_waiting});
      check("cyc_halted", {31'd0, bus.halted}, {31'd0, m_parked});
      check("cyc_instr", {20'd0, bus.instr}, {20'd0, m_instr});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (bus.instr_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Called at a falling edge with instr_valid high; one transfer.
  task automatic accept_one(input logic jmp, input logic [7:0] addr);
    bus.instr_ready = 1'b1;
    bus.jump_en     = jmp;
    bus.jump_addr   = addr;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.jump_en     = 1'b0;
    bus.jump_addr   = 8'h00;
  endtask

  task automatic expect_out(input string name, input logic [11:0] ins, input logic [7:0] p);
    check({name, "_instr"}, {20'd0, bus.instr}, {20'd0, ins});
    check({name, "_pc"}, {24'd0, bus.pc}, {24'd0, p});
    check({name, "_valid"}, {31'd0, bus.instr_valid}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 12'h100 + 12'(i);
    rom[0]   = 12'h0AA;
    rom[1]   = 12'hF00;
    rom[2]   = 12'h500;
    rom[3]   = 12'hF00;
    rom[14]  = 12'h9FF;
    rom[255] = 12'h7AB;
    bus.instr_ready = 1'b0;
    bus.jump_en     = 1'b0;
    bus.jump_addr   = 8'h00;
    bus.resume      = 1'b0;

    #12;
    check("rst_pc", {24'd0, bus.pc}, 32'd1);
    check("rst_rom_addr", {24'd0, bus.rom_addr}, 32'd1);
    check("rst_instr", {20'd0, bus.instr}, 32'd0);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_halted", {31'd0, bus.halted}, 32'd0);
    check("rst_state", {30'd0, bus.state}, 32'd0);

    // Sequential fetch with ready held high for the first transfer.
    @(negedge clk);
    m_enable_cmp    = 1'b1;
    rst             = 1'b0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    expect_out("seq1", 12'hF00, 8'd1);
    @(negedge clk);
    check("seq1_gap_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("seq1_gap_pc", {24'd0, bus.pc}, 32'd2);
    bus.instr_ready = 1'b0;
    wait_valid("seq2");
    expect_out("seq2", 12'h500, 8'd2);

    // Backpressure: 5 cycles stalled, with a stray resume pulse (ignored).
    for (int i = 0; i < 5; i++) begin
      bus.resume = (i == 2);
      @(negedge clk);
      expect_out("stall", 12'h500, 8'd2);
    end
    bus.resume = 1'b0;
    accept_one(1'b0, 8'h00);
    wait_valid("seq3");
    expect_out("seq3", 12'hF00, 8'd3);

    // Walk to pc = 6.
    accept_one(1'b0, 8'h00); wait_valid("seq4");
    accept_one(1'b0, 8'h00); wait_valid("seq5");
    accept_one(1'b0, 8'h00); wait_valid("seq6");
    expect_out("seq6", 12'h106, 8'd6);

    // jump_en without ready has no effect.
    bus.jump_en   = 1'b1;
    bus.jump_addr = 8'h02;
    repeat (2) @(negedge clk);
    expect_out("jmp_noready", 12'h106, 8'd6);
    accept_one(1'b1, 8'h02);
    check("jmp_gap_pc", {24'd0, bus.pc}, 32'd2);
    wait_valid("jmp");
    expect_out("jmp", 12'h500, 8'd2);

    // Wrap from 255 goes to RESET_PC.
    accept_one(1'b1, 8'hFF);
    wait_valid("to_ff");
    expect_out("to_ff", 12'h7AB, 8'hFF);
    accept_one(1'b0, 8'h00);
    wait_valid("wrap");
    expect_out("wrap", 12'hF00, 8'd1);

    // Jump to address 0 is honoured.
    accept_one(1'b1, 8'h00);
    wait_valid("jmp0");
    expect_out("jmp0", 12'h0AA, 8'd0);

    // HALT sentinel at 14, reached sequentially from 13.
    accept_one(1'b1, 8'd13);
    wait_valid("pre_halt");
    expect_out("pre_halt", 12'h10D, 8'd13);
    accept_one(1'b0, 8'h00);
    @(negedge clk);
`ifdef FETCH_HALT_DETECT_EN
    check("halt_halted", {31'd0, bus.halted}, 32'd1);
    check("halt_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("halt_pc", {24'd0, bus.pc}, 32'd14);
    bus.instr_ready = 1'b1;
    bus.jump_en     = 1'b1;
    bus.jump_addr   = 8'h40;
    repeat (3) @(negedge clk);
    check("halt_hold_pc", {24'd0, bus.pc}, 32'd14);
    check("halt_hold_halted", {31'd0, bus.halted}, 32'd1);
    bus.instr_ready = 1'b0;
    bus.jump_en     = 1'b0;
    bus.resume      = 1'b1;
    @(negedge clk);
    bus.resume      = 1'b0;
    check("resume_pc", {24'd0, bus.pc}, 32'd1);
    check("resume_halted", {31'd0, bus.halted}, 32'd0);
    @(negedge clk);
    expect_out("resume", 12'hF00, 8'd1);
`else
    expect_out("halt_word", 12'h9FF, 8'd14);
    check("nohalt_halted", {31'd0, bus.halted}, 32'd0);
    accept_one(1'b0, 8'h00);
    check("nohalt_pc", {24'd0, bus.pc}, 32'd15);
    wait_valid("after9ff");
`endif

    // Async reset while an instruction is pending at pc = 9.
    accept_one(1'b1, 8'd9);
    wait_valid("pc9");
    expect_out("pc9", 12'h109, 8'd9);
    #2 rst = 1'b1;
    #1;
    check("arst_pc", {24'd0, bus.pc}, 32'd1);
    check("arst_instr", {20'd0, bus.instr}, 32'd0);
    check("arst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("arst_halted", {31'd0, bus.halted}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_valid("post_rst");
    expect_out("post_rst", 12'hF00, 8'd1);

    @(negedge clk);
    m_enable_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
